bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255: number of MCLK cycles waited for DTACK/BERR before aborting a cycle.
REQ-002 MCLK_IN  input  1  system clock; all logic on its rising edge.
REQ-003 RESET_IN  input  1  reset; asynchronous, active-high.
REQ-004 REQ_IN  input  1  command request, sampled only while BUSY=0.
REQ-005 REQ_WR_IN  input  1  1=write, 0=read.
REQ_SIZE_IN  input  1  1=word, 0=byte.
REQ-006 REQ_ADDR_IN  input  24  byte address; bit 0 selects the byte lane.
REQ-007 REQ_WDATA_IN  input  16  write data; a byte write uses [7:0].
REQ-008 BG_IN, CPU_AS_IN, DTACK_IN, BERR_IN  input  1 each  bus grant, CPU address strobe, data acknowledge, bus error; all active-high internal polarity.
REQ-009 DATA_IN  input  16  sampled data bus.
REQ-010 BR, BGACK, AS, UDS, LDS, WR  output  1 each  bus request/ownership/strobe/direction; active-high.
REQ-011 ADDR  output  24  driven address.
DATA_OUT  output  16  write data.
DATA_OE  output  1  data-bus drive enable.
ADDR_OE  output  1  address/control drive enable.
REQ-012 BUSY  output  1  command in progress.
ACK  output  1  one-cycle success pulse.
ERR  output  1  one-cycle failure pulse.
RDATA  output  16  read result.

Function
REQ-013 States SHALL be IDLE, ARB, SETUP, STROBE, WAIT, TERM and RELEASE.
REQ-014 IDLE: on REQ_IN=1, the module SHALL latch all REQ_* inputs and set BUSY=1 on the next edge.
- Word request with REQ_ADDR_IN[0]=1: go to TERM with ERR, never asserting BR.
- Otherwise: go to ARB.
REQ-015 ARB: BR=1; advance to SETUP on the first edge where BG_IN=1, CPU_AS_IN=0 and DTACK_IN=0 are all true.
REQ-016 SETUP (exactly 1 cycle):
- BR=0, BGACK=1, ADDR_OE=1.
- ADDR=latched address with bit 0 forced 0.
- WR=latched direction.
- DATA_OE=WR.
REQ-017 Write data: word writes SHALL drive DATA_OUT=WDATA; byte writes SHALL drive {WDATA[7:0],WDATA[7:0]} on both lanes.
REQ-018 STROBE (1 cycle): AS=1, with data strobes as follows.
- Word: UDS=LDS=1.
- Byte with A0=0: UDS only.
- Byte with A0=1: LDS only.
REQ-019 WAIT: strobes held; the timeout counter SHALL increment from 0 each cycle.
REQ-020 WAIT exit conditions:
- DTACK_IN=1 sampled: latch read data, go to TERM with success.
- BERR_IN=1: go to TERM with error; BERR SHALL take priority over a simultaneous DTACK.
- Counter reaches TIMEOUT-1: go to TERM with error.
REQ-021 RDATA latching:
- Word read: RDATA=DATA_IN.
- Byte read at A0=0: RDATA={8'h00,DATA_IN[15:8]}.
- Byte read at A0=1: RDATA={8'h00,DATA_IN[7:0]}.
- RDATA SHALL be unchanged on error and on writes.
REQ-022 TERM (1 cycle): AS=UDS=LDS=0, DATA_OE=0, ADDR still driven; ACK or ERR pulses for exactly this cycle.
REQ-023 RELEASE: remain until DTACK_IN=0 and BERR_IN=0, then drop BGACK and ADDR_OE, return to IDLE and set BUSY=0.
REQ-024 Latency: with BG_IN already high and DTACK returned in the first WAIT cycle, ACK SHALL occur 5 cycles after the REQ_IN sampling edge.
REQ-025 REQ_IN while BUSY=1 SHALL be ignored, with no queueing.
REQ-026 ACK and ERR SHALL never be asserted in the same cycle.
REQ-027 BR and BGACK SHALL never both be 1.

Reset
REQ-028 RESET_IN=1 SHALL immediately set the state to IDLE and force outputs as follows:
- BR, BGACK, AS, UDS, LDS, WR, DATA_OE, ADDR_OE, ACK, ERR and BUSY = 0.
- ADDR=0, DATA_OUT=0, RDATA=0.
- Timeout counter = 0.
REQ-029 Reset mid-cycle SHALL release the bus without emitting ACK or ERR.

Structure
REQ-030 The state encoding, the size/direction constants and the TIMEOUT default SHALL live in a shared package, bus_pkg, also used by the bus-control responder.
REQ-031 The byte-lane steering (UDS/LDS decode, write replication, read extraction) SHALL be one combinational sub-module, byte_lane; everything else stays flat.

Verification
REQ-032 Word write: 0x100000, data 0xBEEF, BG immediate, DTACK in first WAIT cycle -> UDS=LDS=1, DATA_OUT=0xBEEF, ACK 5 cycles after request.
REQ-033 Byte reads: 0x000001 with DATA_IN=0x12AB -> LDS only, RDATA=0x00AB; 0x000000 -> UDS only, RDATA=0x0012.
REQ-034 Arbitration: BG_IN delayed 10 cycles, CPU_AS_IN=1 for 3 further cycles -> BR held throughout, BGACK rises only after CPU_AS_IN=0.
REQ-035 Errors: misaligned word 0x000003 -> ERR, BR never asserted; DTACK and BERR in the same cycle -> ERR only; TIMEOUT=8 with no DTACK -> ERR after 8 WAIT cycles.
REQ-036 RESET_IN asserted during WAIT -> all strobes and BGACK low in the same cycle, no ACK/ERR, BUSY=0.
REQ-037 REQ_IN held high for 20 cycles -> exactly one bus cycle executed per IDLE entry.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: bus-cycle states, size/direction encodings and timeout default shared by master and responder
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SETUP,
        STROBE,
        WAIT,
        TERM,
        RELEASE
    } bus_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/byte_lane.sv
// byte_lane: data-strobe decode, write-lane replication and read-byte extraction
module byte_lane
    import bus_pkg::*;
(
    input  logic        size,
    input  logic        a0,
    input  logic [15:0] wdata,
    input  logic [15:0] bus_rdata,
    output logic        uds,
    output logic        lds,
    output logic [15:0] bus_wdata,
    output logic [15:0] rdata
);

    // even byte lives on the upper lane, odd byte on the lower lane
    assign uds       = (size == SIZE_WORD) || !a0;
    assign lds       = (size == SIZE_WORD) || a0;
    assign bus_wdata = (size == SIZE_BYTE) ? {wdata[7:0], wdata[7:0]} : wdata;
    assign rdata     = (size == SIZE_WORD) ? bus_rdata
                     : {8'h00, a0 ? bus_rdata[7:0] : bus_rdata[15:8]};

endmodule

// File: rtl/bus_master.sv
// bus_master: single-command bus master with arbitration, byte lanes, timeout and error handling
module bus_master
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        MCLK_IN,
    input  logic        RESET_IN,
    input  logic        REQ_IN,
    input  logic        REQ_WR_IN,
    input  logic        REQ_SIZE_IN,
    input  logic [23:0] REQ_ADDR_IN,
    input  logic [15:0] REQ_WDATA_IN,
    input  logic        BG_IN,
    input  logic        CPU_AS_IN,
    input  logic        DTACK_IN,
    input  logic        BERR_IN,
    input  logic [15:0] DATA_IN,
    output logic        BR,
    output logic        BGACK,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        WR,
    output logic [23:0] ADDR,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    output logic        ADDR_OE,
    output logic        BUSY,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA
);

    localparam int CW = $clog2(TIMEOUT + 1);

    bus_state_t      state_q, state_d;
    logic            wr_q, wr_d;
    logic            size_q, size_d;
    logic [23:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            own_q, own_d;

    logic            lane_uds, lane_lds;
    logic [15:0]     lane_wdata, lane_rdata;
    logic            strobe;

    byte_lane u_lane (
        .size      (size_q),
        .a0        (addr_q[0]),
        .wdata     (wdata_q),
        .bus_rdata (DATA_IN),
        .uds       (lane_uds),
        .lds       (lane_lds),
        .bus_wdata (lane_wdata),
        .rdata     (lane_rdata)
    );

    // state and command registers; reset drops ownership so the bus is released at once
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q <= IDLE;
            wr_q    <= DIR_READ;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            own_q   <= own_d;
        end
    end

    // next-state: command latch, arbitration, wait/timeout handling and release
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        own_d   = own_q;
        case (state_q)
            IDLE: begin
                if (REQ_IN) begin
                    wr_d    = REQ_WR_IN;
                    size_d  = REQ_SIZE_IN;
                    addr_d  = REQ_ADDR_IN;
                    wdata_d = REQ_WDATA_IN;
                    err_d   = (REQ_SIZE_IN == SIZE_WORD) && REQ_ADDR_IN[0];
                    state_d = err_d ? TERM : ARB;
                end
            end
            ARB: begin
                if (BG_IN && !CPU_AS_IN && !DTACK_IN) begin
                    own_d   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (BERR_IN) begin
                    err_d   = 1'b1;
                    state_d = TERM;
                end else if (DTACK_IN) begin
                    err_d   = 1'b0;
                    rdata_d = (wr_q == DIR_READ) ? lane_rdata : rdata_q;
                    state_d = TERM;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = TERM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TERM: state_d = RELEASE;
            RELEASE: begin
                if (!DTACK_IN && !BERR_IN) begin
                    own_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign strobe   = (state_q == STROBE) || (state_q == WAIT);
    assign BR       = (state_q == ARB);
    assign BGACK    = own_q;
    assign ADDR_OE  = own_q;
    assign AS       = strobe;
    assign UDS      = strobe && lane_uds;
    assign LDS      = strobe && lane_lds;
    assign WR       = own_q && (wr_q == DIR_WRITE);
    assign DATA_OE  = WR && (state_q inside {SETUP, STROBE, WAIT});
    assign ADDR     = own_q ? {addr_q[23:1], 1'b0} : '0;
    assign DATA_OUT = DATA_OE ? lane_wdata : '0;
    assign BUSY     = (state_q != IDLE);
    assign ACK      = (state_q == TERM) && !err_q;
    assign ERR      = (state_q == TERM) && err_q;
    assign RDATA    = rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed table-driven and sequence checks for bus_master
module tb_bus_master;

    logic        MCLK_IN = 1'b0;
    logic        RESET_IN = 1'b1;
    logic        REQ_IN = 1'b0;
    logic        REQ_WR_IN = 1'b0;
    logic        REQ_SIZE_IN = 1'b0;
    logic [23:0] REQ_ADDR_IN = '0;
    logic [15:0] REQ_WDATA_IN = '0;
    logic        BG_IN = 1'b0;
    logic        CPU_AS_IN = 1'b0;
    logic        DTACK_IN = 1'b0;
    logic        BERR_IN = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic        BR, BGACK, AS, UDS, LDS, WR, DATA_OE, ADDR_OE, BUSY, ACK, ERR;
    logic [23:0] ADDR;
    logic [15:0] DATA_OUT, RDATA;

    int n_chk = 0;
    int n_fail = 0;

    bus_master #(.TIMEOUT(8)) dut (
        .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN), .REQ_IN(REQ_IN), .REQ_WR_IN(REQ_WR_IN),
        .REQ_SIZE_IN(REQ_SIZE_IN), .REQ_ADDR_IN(REQ_ADDR_IN), .REQ_WDATA_IN(REQ_WDATA_IN),
        .BG_IN(BG_IN), .CPU_AS_IN(CPU_AS_IN), .DTACK_IN(DTACK_IN), .BERR_IN(BERR_IN),
        .DATA_IN(DATA_IN), .BR(BR), .BGACK(BGACK), .AS(AS), .UDS(UDS), .LDS(LDS), .WR(WR),
        .ADDR(ADDR), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .ADDR_OE(ADDR_OE),
        .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA)
    );

    always #5 MCLK_IN = ~MCLK_IN;

    typedef struct {
        logic        wr;
        logic        size;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic        uds;
        logic        lds;
        logic [15:0] dout;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        int          br_n;
        int          bgack_n;
        int          as_n;
        int          ack_n;
        int          err_n;
        int          term_cyc;
        logic        uds;
        logic        lds;
        logic        wr;
        logic        data_oe;
        logic [23:0] addr;
        logic [15:0] dout;
    } obs_t;

    vec_t vecs[7];
    obs_t o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic size, input logic [23:0] addr, input logic [15:0] wdata);
        @(negedge MCLK_IN);
        REQ_WR_IN = wr;
        REQ_SIZE_IN = size;
        REQ_ADDR_IN = addr;
        REQ_WDATA_IN = wdata;
        REQ_IN = 1'b1;
        @(posedge MCLK_IN);
        #1 REQ_IN = 1'b0;
    endtask

    // observes cycles 1.. after the sampling edge until BUSY drops; optional DTACK responder
    task automatic watch(input bit auto_ack, output obs_t ob);
        bit done = 1'b0;
        ob = '{default: 0};
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge MCLK_IN);
            if (BR) ob.br_n++;
            if (BGACK) ob.bgack_n++;
            if (AS) begin
                if (ob.as_n == 0) begin
                    ob.uds = UDS;
                    ob.lds = LDS;
                    ob.wr = WR;
                    ob.data_oe = DATA_OE;
                    ob.addr = ADDR;
                    ob.dout = DATA_OUT;
                end
                ob.as_n++;
            end
            if (ACK) ob.ack_n++;
            if (ERR) ob.err_n++;
            if ((ACK || ERR) && ob.term_cyc == 0) ob.term_cyc = i;
            if (auto_ack) DTACK_IN = AS;
            done = !BUSY;
        end
        DTACK_IN = 1'b0;
        chk("watch_done", {31'd0, done}, 32'd1);
    endtask

    // protocol invariants every cycle outside reset
    always @(negedge MCLK_IN) begin
        if (!RESET_IN) begin
            n_chk++;
            if ((ACK && ERR) || (BR && BGACK)) begin
                n_fail++;
                $display("FAIL invariant: ACK=%0b ERR=%0b BR=%0b BGACK=%0b", ACK, ERR, BR, BGACK);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ack_n, br_rise;
        logic br_prev;
        vecs[0] = '{1'b1, 1'b1, 24'h100000, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 24'h000001, 16'h0000, 16'h12AB, 1'b0, 1'b1, 16'h0000, 16'h00AB};
        vecs[2] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 16'h12AB, 1'b1, 1'b0, 16'h0000, 16'h0012};
        vecs[3] = '{1'b0, 1'b1, 24'h00ABCE, 16'h0000, 16'h5A5A, 1'b1, 1'b1, 16'h0000, 16'h5A5A};
        vecs[4] = '{1'b1, 1'b0, 24'h000201, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h3434, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 24'h000200, 16'h12CD, 16'h0000, 1'b1, 1'b0, 16'hCDCD, 16'h5A5A};
        vecs[6] = '{1'b0, 1'b1, 24'hFFFFFE, 16'h0000, 16'h8001, 1'b1, 1'b1, 16'h0000, 16'h8001};

        #1;
        chk("reset_ctl", {21'd0, BR, BGACK, AS, UDS, LDS, WR, DATA_OE, ADDR_OE, BUSY, ACK, ERR}, 32'd0);
        chk("reset_addr", {8'd0, ADDR}, 32'd0);
        chk("reset_dout", {16'd0, DATA_OUT}, 32'd0);
        chk("reset_rdata", {16'd0, RDATA}, 32'd0);
        repeat (2) @(negedge MCLK_IN);
        RESET_IN = 1'b0;

        BG_IN = 1'b1;
        for (int k = 0; k < 7; k++) begin
            DATA_IN = vecs[k].din;
            issue(vecs[k].wr, vecs[k].size, vecs[k].addr, vecs[k].wdata);
            watch(1'b1, o);
            chk($sformatf("v%0d_uds", k), {31'd0, o.uds}, {31'd0, vecs[k].uds});
            chk($sformatf("v%0d_lds", k), {31'd0, o.lds}, {31'd0, vecs[k].lds});
            chk($sformatf("v%0d_wr", k), {31'd0, o.wr}, {31'd0, vecs[k].wr});
            chk($sformatf("v%0d_data_oe", k), {31'd0, o.data_oe}, {31'd0, vecs[k].wr});
            chk($sformatf("v%0d_addr", k), {8'd0, o.addr}, {8'd0, vecs[k].addr[23:1], 1'b0});
            if (vecs[k].wr) chk($sformatf("v%0d_dout", k), {16'd0, o.dout}, {16'd0, vecs[k].dout});
            chk($sformatf("v%0d_ack_cycle", k), o.term_cyc, 5);
            chk($sformatf("v%0d_ack_n", k), o.ack_n, 1);
            chk($sformatf("v%0d_err_n", k), o.err_n, 0);
            chk($sformatf("v%0d_rdata", k), {16'd0, RDATA}, {16'd0, vecs[k].rdata});
        end

        // arbitration: grant late, then CPU still owns the bus; stray REQ while busy ignored
        BG_IN = 1'b0;
        CPU_AS_IN = 1'b0;
        DATA_IN = 16'h4321;
        issue(1'b0, 1'b1, 24'h000010, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge MCLK_IN);
            chk("arb_br_nogrant", {31'd0, BR}, 32'd1);
            chk("arb_bgack_nogrant", {31'd0, BGACK}, 32'd0);
            if (i == 1) begin
                REQ_IN = 1'b1;
                REQ_ADDR_IN = 24'h00FFFE;
            end
            if (i == 3) REQ_IN = 1'b0;
        end
        BG_IN = 1'b1;
        CPU_AS_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge MCLK_IN);
            chk("arb_br_cpu_as", {31'd0, BR}, 32'd1);
            chk("arb_bgack_cpu_as", {31'd0, BGACK}, 32'd0);
        end
        CPU_AS_IN = 1'b0;
        @(negedge MCLK_IN);
        chk("arb_bgack_rise", {31'd0, BGACK}, 32'd1);
        chk("arb_br_drop", {31'd0, BR}, 32'd0);
        chk("arb_addr_latched", {8'd0, ADDR}, 32'h000010);
        watch(1'b1, o);
        chk("arb_ack_n", o.ack_n, 1);
        chk("arb_rdata", {16'd0, RDATA}, 32'h4321);
        @(negedge MCLK_IN);
        chk("arb_no_queue", {31'd0, BUSY}, 32'd0);

        // DTACK and BERR together: error wins, read data untouched
        DATA_IN = 16'hFFFF;
        issue(1'b0, 1'b1, 24'h000020, 16'h0000);
        repeat (4) @(negedge MCLK_IN);
        chk("dual_in_wait", {31'd0, AS}, 32'd1);
        DTACK_IN = 1'b1;
        BERR_IN = 1'b1;
        @(negedge MCLK_IN);
        chk("dual_err", {31'd0, ERR}, 32'd1);
        chk("dual_ack", {31'd0, ACK}, 32'd0);
        DTACK_IN = 1'b0;
        BERR_IN = 1'b0;
        watch(1'b0, o);
        chk("dual_rdata", {16'd0, RDATA}, 32'h4321);

        // timeout with TIMEOUT=8: one STROBE plus eight WAIT cycles, TERM in cycle 12
        issue(1'b0, 1'b1, 24'h000040, 16'h0000);
        watch(1'b0, o);
        chk("tmo_as_cycles", o.as_n, 9);
        chk("tmo_term_cycle", o.term_cyc, 12);
        chk("tmo_err_n", o.err_n, 1);
        chk("tmo_ack_n", o.ack_n, 0);
        chk("tmo_rdata", {16'd0, RDATA}, 32'h4321);

        // misaligned word: immediate error, no bus request
        issue(1'b0, 1'b1, 24'h000003, 16'h0000);
        watch(1'b0, o);
        chk("mis_br_n", o.br_n, 0);
        chk("mis_bgack_n", o.bgack_n, 0);
        chk("mis_err_n", o.err_n, 1);
        chk("mis_ack_n", o.ack_n, 0);
        chk("mis_term_cycle", o.term_cyc, 1);

        // reset during WAIT releases the bus immediately
        issue(1'b0, 1'b1, 24'h000050, 16'h0000);
        repeat (4) @(negedge MCLK_IN);
        chk("rst_in_wait", {31'd0, AS}, 32'd1);
        RESET_IN = 1'b1;
        #1;
        chk("rst_async_ctl", {23'd0, AS, UDS, LDS, BGACK, BR, ADDR_OE, BUSY, ACK, ERR}, 32'd0);
        @(negedge MCLK_IN);
        chk("rst_hold_ackerr", {30'd0, ACK, ERR}, 32'd0);
        RESET_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge MCLK_IN);
            chk("rst_after", {29'd0, ACK, ERR, BUSY}, 32'd0);
        end
        chk("rst_rdata", {16'd0, RDATA}, 32'd0);

        // REQ_IN held high: one bus cycle per IDLE entry, seven cycles each
        @(negedge MCLK_IN);
        REQ_WR_IN = 1'b1;
        REQ_SIZE_IN = 1'b1;
        REQ_ADDR_IN = 24'h000100;
        REQ_WDATA_IN = 16'h5555;
        REQ_IN = 1'b1;
        ack_n = 0;
        br_rise = 0;
        br_prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK_IN);
            if (ACK) ack_n++;
            if (BR && !br_prev) br_rise++;
            br_prev = BR;
            DTACK_IN = AS;
        end
        REQ_IN = 1'b0;
        DTACK_IN = 1'b0;
        chk("hold_ack_n", ack_n, 3);
        chk("hold_br_rise", br_rise, 3);
        watch(1'b0, o);
        @(negedge MCLK_IN);
        chk("hold_idle", {31'd0, BUSY}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
